// File: rtl/btn_event_gen.sv
// Turns a debounced button level into press / release / long-press / auto-repeat strobes.
// Every output is registered; the counter advances only on the tick time-base strobe.
module btn_event_gen #(
    parameter int unsigned HOLD_TICKS   = 500,
    parameter int unsigned REPEAT_TICKS = 100,
    parameter int unsigned CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic holding
);

    // Terminal counts: the tick that sees cnt at this value is the HOLD/REPEAT-th one.
    localparam logic [CNT_W-1:0] HoldLast   = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] RepeatLast = CNT_W'(REPEAT_TICKS - 1);

    typedef enum logic [1:0] {
        StWaitLow,
        StIdle,
        StPressed,
        StRepeat
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              repeat_q, repeat_d;
    logic              holding_q, holding_d;

    // Next state, counter and strobes; release wins over a tick on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            // Button may already be down out of reset; require a low level before arming.
            StWaitLow: begin
                if (!level) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (level) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            StPressed: begin
                if (!level) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (cnt_q == HoldLast) begin
                        state_d  = StRepeat;
                        cnt_d    = '0;
                        long_d   = 1'b1;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StRepeat: begin
                if (!level) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (cnt_q == RepeatLast) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StWaitLow;
                cnt_d   = '0;
            end
        endcase

        holding_d = (state_d == StRepeat);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StWaitLow;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            holding_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            holding_q <= holding_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign holding       = holding_q;

endmodule

// File: tb/tb_btn_event_gen.sv
// Scoreboard bench: three parameterisations share one stimulus stream; a behavioural model
// counts ticks since the press and pushes the expected outputs, a monitor pops and compares.
module tb_btn_event_gen;

    localparam int N = 3;

    function automatic int hold_of(input int g);
        return (g == 0) ? 4 : (g == 1) ? 3 : 1;
    endfunction

    function automatic int rep_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 3 : 1;
    endfunction

    logic clk = 1'b0;
    logic rst, tick, level;
    logic [N-1:0] press, rel, lng, rep, hold;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        btn_event_gen #(
            .HOLD_TICKS  (hold_of(g)),
            .REPEAT_TICKS(rep_of(g)),
            .CNT_W       (16)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .level        (level),
            .press_pulse  (press[g]),
            .release_pulse(rel[g]),
            .long_pulse   (lng[g]),
            .repeat_pulse (rep[g]),
            .holding      (hold[g])
        );
    end

    typedef struct packed {
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic [N-1:0] l;
        logic [N-1:0] rp;
        logic [N-1:0] h;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model: armed = low level seen since reset, down = press accepted,
    // n = ticks seen since the press was accepted.
    bit armed [N];
    bit down  [N];
    int n     [N];

    task automatic step(input logic r, input logic t, input logic l);
        exp_t e;
        int   hh, rr;
        @(negedge clk);
        #1;
        rst   = r;
        tick  = t;
        level = l;
        e     = '0;
        for (int g = 0; g < N; g++) begin
            hh = hold_of(g);
            rr = rep_of(g);
            if (r) begin
                armed[g] = 1'b0;
                down[g]  = 1'b0;
                n[g]     = 0;
            end else if (!armed[g]) begin
                if (!l) armed[g] = 1'b1;
            end else if (!down[g]) begin
                if (l) begin
                    down[g] = 1'b1;
                    n[g]    = 0;
                    e.p[g]  = 1'b1;
                end
            end else if (!l) begin
                down[g] = 1'b0;
                n[g]    = 0;
                e.r[g]  = 1'b1;
            end else if (t) begin
                n[g] = n[g] + 1;
                if (n[g] == hh) begin
                    e.l[g]  = 1'b1;
                    e.rp[g] = 1'b1;
                end else if (n[g] > hh && ((n[g] - hh) % rr) == 0) begin
                    e.rp[g] = 1'b1;
                end
            end
            e.h[g] = !r && down[g] && (n[g] >= hh);
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string nm, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", nm, cyc, got, want);
        end
    endtask

    // Monitor: outputs after each posedge are compared at the following negedge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("press_pulse", press, e.p);
            check("release_pulse", rel, e.r);
            check("long_pulse", lng, e.l);
            check("repeat_pulse", rep, e.rp);
            check("holding", hold, e.h);
        end
    end

    initial begin
        logic lv;
        rst   = 1'b1;
        tick  = 1'b0;
        level = 1'b1;

        // Button held through reset and afterwards: nothing until it goes low then high.
        repeat (3) step(1'b1, 1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Short press shorter than the hold time.
        repeat (3) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Long hold into an auto-repeat stream.
        repeat (13) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);

        // Sparse tick: counter frozen between ticks.
        for (int i = 0; i < 60; i++) step(1'b0, (i % 10) == 9, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Release on the terminal tick edge of the hold-4 instance, then a fresh press.
        repeat (4) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b1, 1'b0);

        // Reset in the middle of a repeat stream with the button still held.
        repeat (15) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        repeat (10) step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0);

        // Random level with mixed hold lengths, random ticks and occasional reset.
        lv = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                if ($urandom_range(0, 7) == 0) lv = ~lv;
            end else begin
                if ($urandom_range(0, 29) == 0) lv = ~lv;
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, lv);
        end
        step(1'b0, 1'b0, 1'b0);

        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
